spi_target: RTL

- SPI mode-0 target (slave): the far end of the link driven by our SPI master block. Owns an 8-word x 32-bit register bank written and read over SPI frames.
- Oversamples sclk/ss/mosi on the system clock. Reports each completed write frame on a parallel side-band port to on-chip logic.
- Sits on the peripheral side of the SPI pins, opposite the OBI-fronted SPI master.

---
 rtl/spi_target_pkg.sv | 22 ++
 rtl/spi_target_if.sv | 33 +++
 rtl/spi_sync_edge.sv | 36 +++
 rtl/spi_target.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI target and its matching master: FSM
// states and the frame-format constants both ends agree on.
package spi_target_pkg;

    // Frame-level FSM states of the target.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    // Position of the read/write flag inside the command byte (1 = write).
    localparam int CMD_RW_BIT = 7;

    // Default frame geometry; the SPI master builds frames with the same values.
    localparam int DEFAULT_CMD_WIDTH   = 8;
    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_NUM_WORDS   = 8;
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_target_if.sv
// Pin-level SPI link plus the write side-band port of the SPI target.
// Signal suffixes are written from the target's point of view.
interface spi_target_if
    import spi_target_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_WORDS  = DEFAULT_NUM_WORDS
);
    localparam int AW = $clog2(NUM_WORDS);

    logic                  spi_ss_i;
    logic                  spi_sclk_i;
    logic                  spi_mosi_i;
    logic                  spi_miso_o;
    logic                  spi_miso_oe_o;
    logic                  wr_valid_o;
    logic [AW-1:0]         wr_addr_o;
    logic [DATA_WIDTH-1:0] wr_data_o;
    logic                  frame_err_o;

    modport slave (
        input  spi_ss_i, spi_sclk_i, spi_mosi_i,
        output spi_miso_o, spi_miso_oe_o,
        output wr_valid_o, wr_addr_o, wr_data_o, frame_err_o
    );

    modport master (
        output spi_ss_i, spi_sclk_i, spi_mosi_i,
        input  spi_miso_o, spi_miso_oe_o,
        input  wr_valid_o, wr_addr_o, wr_data_o, frame_err_o
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Brings an asynchronous SPI pin into the system clock domain and flags
// its rising and falling edges as registered one-cycle pulses.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   hist_q;
    logic                   rise_q;
    logic                   fall_q;

    // Synchronizer chain, history flop and edge pulses, one cycle after the synced value moves.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chain_q <= '0;
            hist_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
            hist_q  <= chain_q[SYNC_STAGES-1];
            rise_q  <= chain_q[SYNC_STAGES-1] & ~hist_q;
            fall_q  <= ~chain_q[SYNC_STAGES-1] & hist_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target owning a small register bank. Frames are a command
// byte (write flag + word address) followed by one data word, MSB first.
// Completed writes are echoed on a side-band port; frames cut short by
// slave-select rising are dropped and flagged.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int NUM_WORDS   = DEFAULT_NUM_WORDS,
    parameter int CMD_WIDTH   = DEFAULT_CMD_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic        clk_i,
    input  logic        rst_i,
    spi_target_if.slave bus
);

    localparam int AW       = $clog2(NUM_WORDS);
    localparam int MAX_BITS = (DATA_WIDTH > CMD_WIDTH) ? DATA_WIDTH : CMD_WIDTH;
    localparam int CNT_W    = $clog2(MAX_BITS);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    logic sclkRise, sclkFall, ssRise, ssFall;
    logic mosiSync;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      bitCnt_q, bitCnt_d;
    logic [CMD_WIDTH-2:0]  cmdSr_q, cmdSr_d;
    logic [DATA_WIDTH-2:0] rxSr_q, rxSr_d;
    logic [DATA_WIDTH-1:0] txSr_q, txSr_d;
    logic                  rw_q, rw_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  miso_q, miso_d;
    logic                  wrValid_q, wrValid_d;
    logic [AW-1:0]         wrAddr_q, wrAddr_d;
    logic [DATA_WIDTH-1:0] wrData_q, wrData_d;
    logic                  frameErr_q, frameErr_d;
    logic                  bankWe;
    logic [DATA_WIDTH-1:0] bank_q [NUM_WORDS];
    logic [SYNC_STAGES:0]  mosiChain_q;
    logic [CMD_WIDTH-1:0]  fullCmd;
    logic [DATA_WIDTH-1:0] fullData;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (bus.spi_sclk_i),
        .rise_o (sclkRise),
        .fall_o (sclkFall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (bus.spi_ss_i),
        .rise_o (ssRise),
        .fall_o (ssFall)
    );

    // MOSI delayed by synchronizer depth plus history so it lines up with the sclk edge pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mosiChain_q <= '0;
        end else begin
            mosiChain_q <= {mosiChain_q[SYNC_STAGES-1:0], bus.spi_mosi_i};
        end
    end

    assign mosiSync = mosiChain_q[SYNC_STAGES];

    // State register plus all frame datapath registers and the register bank.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            cmdSr_q    <= '0;
            rxSr_q     <= '0;
            txSr_q     <= '0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            miso_q     <= 1'b0;
            wrValid_q  <= 1'b0;
            wrAddr_q   <= '0;
            wrData_q   <= '0;
            frameErr_q <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            cmdSr_q    <= cmdSr_d;
            rxSr_q     <= rxSr_d;
            txSr_q     <= txSr_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            miso_q     <= miso_d;
            wrValid_q  <= wrValid_d;
            wrAddr_q   <= wrAddr_d;
            wrData_q   <= wrData_d;
            frameErr_q <= frameErr_d;
            if (bankWe) begin
                bank_q[addr_q] <= wrData_d;
            end
        end
    end

    // Next-state and datapath update; an ss rise always outranks an sclk edge in the same cycle.
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        cmdSr_d    = cmdSr_q;
        rxSr_d     = rxSr_q;
        txSr_d     = txSr_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        miso_d     = miso_q;
        wrValid_d  = 1'b0;
        wrAddr_d   = wrAddr_q;
        wrData_d   = wrData_q;
        frameErr_d = 1'b0;
        bankWe     = 1'b0;
        fullCmd    = {cmdSr_q, mosiSync};
        fullData   = {rxSr_q, mosiSync};

        unique case (state_q)
            IDLE: begin
                if (ssRise) begin
                    miso_d = 1'b0;
                end else if (ssFall) begin
                    state_d  = CMD;
                    bitCnt_d = '0;
                    cmdSr_d  = '0;
                    rxSr_d   = '0;
                    miso_d   = 1'b0;
                end
            end
            CMD: begin
                if (ssRise) begin
                    state_d    = IDLE;
                    frameErr_d = 1'b1;
                    miso_d     = 1'b0;
                end else if (sclkRise) begin
                    cmdSr_d = fullCmd[CMD_WIDTH-2:0];
                    if (bitCnt_q == CMD_LAST) begin
                        rw_d     = fullCmd[CMD_RW_BIT];
                        addr_d   = fullCmd[AW-1:0];
                        bitCnt_d = '0;
                        state_d  = DATA;
                        if (!fullCmd[CMD_RW_BIT]) begin
                            txSr_d = bank_q[fullCmd[AW-1:0]];
                        end
                    end else begin
                        bitCnt_d = bitCnt_q + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (ssRise) begin
                    state_d    = IDLE;
                    frameErr_d = 1'b1;
                    miso_d     = 1'b0;
                end else begin
                    if (sclkFall && !rw_q) begin
                        miso_d = txSr_q[DATA_WIDTH-1];
                        txSr_d = {txSr_q[DATA_WIDTH-2:0], 1'b0};
                    end
                    if (sclkRise) begin
                        if (rw_q) begin
                            rxSr_d = fullData[DATA_WIDTH-2:0];
                        end
                        if (bitCnt_q == DATA_LAST) begin
                            state_d  = DONE;
                            bitCnt_d = '0;
                            miso_d   = 1'b0;
                            if (rw_q) begin
                                bankWe    = 1'b1;
                                wrValid_d = 1'b1;
                                wrAddr_d  = addr_q;
                                wrData_d  = fullData;
                            end
                        end else begin
                            bitCnt_d = bitCnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            DONE: begin
                miso_d = 1'b0;
                if (ssRise) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pin and side-band outputs; the driver is enabled whenever a frame is in progress.
    always_comb begin
        bus.spi_miso_o    = miso_q;
        bus.spi_miso_oe_o = (state_q != IDLE);
        bus.wr_valid_o    = wrValid_q;
        bus.wr_addr_o     = wrAddr_q;
        bus.wr_data_o     = wrData_q;
        bus.frame_err_o   = frameErr_q;
    end

endmodule
